// File: rtl/mem_bus_pkg.sv
// Shared encodings for the memory bus responder: request sizes, FSM states
// and the alignment check used when a request is accepted.
package mem_bus_pkg;

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_RESP = 2'd3
   } state_e;

   // True when the request can never touch the array: illegal size or an
   // address not naturally aligned to the access size.
   function automatic logic is_bad_access(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
      logic bad;
      bad = 1'b0;
      case (size)
         SZ_WORD: bad = (addr_lo != 2'b00);
         SZ_HALF: bad = addr_lo[0];
         SZ_BYTE: bad = 1'b0;
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Lane steering between a 32-bit array word and the bus: extracts the
// addressed byte/half (zero-extended, right-justified) for reads and merges
// right-justified store data into the word for sub-word writes.
module mem_lane_unit
   import mem_bus_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic [31:0] merged
);

   logic [4:0] byte_sh;

   assign byte_sh = {addr_lo, 3'b000};

   // Pick the addressed lane for reads and overlay the store lane for writes;
   // lanes not addressed keep the old word bits unchanged.
   always_comb begin
      rdata  = '0;
      merged = word;
      case (size)
         SZ_WORD: begin
            rdata  = word;
            merged = wdata;
         end
         SZ_HALF: begin
            if (addr_lo[1]) begin
               rdata  = {16'h0000, word[31:16]};
               merged = {wdata[15:0], word[15:0]};
            end else begin
               rdata  = {16'h0000, word[15:0]};
               merged = {word[31:16], wdata[15:0]};
            end
         end
         SZ_BYTE: begin
            rdata                 = {24'h000000, word[byte_sh +: 8]};
            merged[byte_sh +: 8]  = wdata[7:0];
         end
         default: begin
            rdata  = '0;
            merged = word;
         end
      endcase
   end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side bus responder: one request at a time, fixed-latency response,
// sub-word stores done as read-modify-write on a word-wide synchronous array.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | req_ready=1, capture request when req_valid=1
// RD      | array word read into word_q
// WR      | merged word written back to the array
// RESP    | resp_valid=1 for one cycle with registered data/error
module mem_bus_responder
   import mem_bus_pkg::*;
#(
   parameter int DEPTH_LOG2 = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_wr,
   input  logic [1:0]  req_size,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   state_e state, state_nxt;

   logic                  cap_wr;
   logic [1:0]            cap_size;
   logic [1:0]            cap_lo;
   logic [DEPTH_LOG2-1:0] cap_idx;
   logic [31:0]           cap_wdata;
   logic                  cap_err;
   logic [31:0]           word_q;

   logic [31:0]           mem [0:DEPTH-1];

   logic [31:0]           lane_rdata;
   logic [31:0]           lane_merged;
   logic                  req_bad;
   logic                  accept;

   // Upper address bits alias onto the array and are deliberately dropped.
   logic                  addr_unused;
   assign addr_unused = ^req_addr[31:DEPTH_LOG2+2];

   assign req_bad = is_bad_access(req_size, req_addr[1:0]);
   assign accept  = (state == ST_IDLE) && req_valid;

   mem_lane_unit u_lane (
      .size    (cap_size),
      .addr_lo (cap_lo),
      .word    (word_q),
      .wdata   (cap_wdata),
      .rdata   (lane_rdata),
      .merged  (lane_merged)
   );

   // State register; reset aborts any access in flight.
   always_ff @(posedge clk) begin
      if (!reset) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (req_valid) state_nxt = req_bad ? ST_RESP : ST_RD;
         ST_RD:   state_nxt = cap_wr ? ST_WR : ST_RESP;
         ST_WR:   state_nxt = ST_RESP;
         ST_RESP: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Request capture; inputs are only looked at in IDLE.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cap_wr    <= 1'b0;
         cap_size  <= SZ_WORD;
         cap_lo    <= 2'b00;
         cap_idx   <= '0;
         cap_wdata <= '0;
         cap_err   <= 1'b0;
      end else if (accept) begin
         cap_wr    <= req_wr;
         cap_size  <= req_size;
         cap_lo    <= req_addr[1:0];
         cap_idx   <= req_addr[DEPTH_LOG2+1:2];
         cap_wdata <= req_wdata;
         cap_err   <= req_bad;
      end
   end

   // Registered array read in RD; feeds both the read response and the merge.
   always_ff @(posedge clk) begin
      if (!reset)                word_q <= '0;
      else if (state == ST_RD)   word_q <= mem[cap_idx];
   end

   // Array write-back; contents have no reset and survive a reset, and a
   // reset asserted during WR suppresses the write.
   always_ff @(posedge clk) begin
      if (reset && (state == ST_WR)) mem[cap_idx] <= lane_merged;
   end

   // Response outputs come from registered state/capture/word_q and are
   // forced to zero outside RESP.
   always_comb begin
      req_ready  = (state == ST_IDLE);
      resp_valid = (state == ST_RESP);
      resp_err   = (state == ST_RESP) && cap_err;
      resp_rdata = '0;
      if ((state == ST_RESP) && !cap_err && !cap_wr) resp_rdata = lane_rdata;
   end

endmodule

// File: tb/tb_mem_bus_responder.sv
module tb_mem_bus_responder;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_wr;
   logic [1:0]  req_size;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          due;
      string       name;
   } exp_t;

   exp_t exp_q[$];

   mem_bus_responder #(.DEPTH_LOG2(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_wr     (req_wr),
      .req_size   (req_size),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, got, want);
      end
   endtask

   // Monitor: pops the scoreboard whenever a response is presented.
   initial begin
      exp_t e;
      @(posedge clk);
      forever begin
         @(negedge clk);
         if (resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_resp: got resp_valid=1 at cycle %0d required no response", cyc);
            end else begin
               e = exp_q.pop_front();
               check({e.name, "_err"},   {31'b0, resp_err}, {31'b0, e.err});
               check({e.name, "_rdata"}, resp_rdata, e.rdata);
               check({e.name, "_cycle"}, cyc, e.due);
            end
         end else if (reset === 1'b1) begin
            check("idle_outputs_zero", {resp_rdata[31:1], resp_rdata[0] | resp_err}, 32'h0);
         end
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      @(negedge clk);
      while (req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (req_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: got req_ready=%b required 1", req_ready);
      end
   endtask

   task automatic issue(input string name, input logic wr, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rdata,
                        input int lat, input bit hold);
      exp_t e;
      int n;
      wait_ready();
      req_valid = 1'b1;
      req_wr    = wr;
      req_size  = size;
      req_addr  = addr;
      req_wdata = wdata;
      e.err = exp_err; e.rdata = exp_rdata; e.due = cyc + lat; e.name = name;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (!hold) begin
         req_valid = 1'b0;
      end else begin
         // Keep a conflicting request asserted while busy; it must be ignored.
         req_wr    = 1'b0;
         req_addr  = 32'h0000_0010;
         req_wdata = 32'hFFFF_FFFF;
         n = 0;
         @(negedge clk);
         while (resp_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
         end
         req_valid = 1'b0;
      end
   endtask

   initial begin
      int n;
      reset     = 1'b0;
      req_valid = 1'b0;
      req_wr    = 1'b0;
      req_size  = 2'b00;
      req_addr  = '0;
      req_wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready",      {31'b0, req_ready},  32'd1);
      check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      check("rst_rdata",      resp_rdata,          32'd0);
      check("rst_err",        {31'b0, resp_err},   32'd0);
      reset = 1'b1;

      // Word write then read back.
      issue("wr_word",   1, 2'b00, 32'h10, 32'hDEADBEEF, 0, 32'h0,        3, 0);
      issue("rd_word1",  0, 2'b00, 32'h10, 32'h0,        0, 32'hDEADBEEF, 2, 0);
      // Byte merge.
      issue("wr_byte",   1, 2'b10, 32'h13, 32'h000000AB, 0, 32'h0,        3, 0);
      issue("rd_word2",  0, 2'b00, 32'h10, 32'h0,        0, 32'hABADBEEF, 2, 0);
      issue("rd_byte",   0, 2'b10, 32'h11, 32'h0,        0, 32'h000000BE, 2, 0);
      // Half merge.
      issue("wr_half",   1, 2'b01, 32'h12, 32'h00001234, 0, 32'h0,        3, 0);
      issue("rd_word3",  0, 2'b00, 32'h10, 32'h0,        0, 32'h1234BEEF, 2, 0);
      issue("rd_half",   0, 2'b01, 32'h12, 32'h0,        0, 32'h00001234, 2, 0);
      // Error cases: no array access, one-cycle latency.
      issue("err_word",  0, 2'b00, 32'h11, 32'h0,        1, 32'h0,        1, 0);
      issue("err_half",  1, 2'b01, 32'h13, 32'h0000FFFF, 1, 32'h0,        1, 0);
      issue("err_size",  0, 2'b11, 32'h10, 32'h0,        1, 32'h0,        1, 0);
      issue("rd_word4",  0, 2'b00, 32'h10, 32'h0,        0, 32'h1234BEEF, 2, 0);

      // Reset during WR: write suppressed, no response.
      wait_ready();
      req_valid = 1'b1; req_wr = 1'b1; req_size = 2'b10;
      req_addr = 32'h10; req_wdata = 32'h00000077;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      check("rst_mid_ready",      {31'b0, req_ready},  32'd1);
      check("rst_mid_resp_valid", {31'b0, resp_valid}, 32'd0);
      issue("rd_word5",  0, 2'b00, 32'h10, 32'h0,        0, 32'h1234BEEF, 2, 0);

      // Aliasing, held req_valid, sub-word paths at other lanes.
      issue("wr_alias",  1, 2'b00, 32'h400, 32'h55AA55AA, 0, 32'h0,        3, 1);
      issue("rd_alias",  0, 2'b00, 32'h000, 32'h0,        0, 32'h55AA55AA, 2, 0);
      issue("wr_byte1",  1, 2'b10, 32'h401, 32'hFFFFFF77, 0, 32'h0,        3, 0);
      issue("rd_word6",  0, 2'b00, 32'h000, 32'h0,        0, 32'h55AA77AA, 2, 0);
      issue("rd_half_hi",0, 2'b01, 32'h002, 32'h0,        0, 32'h000055AA, 2, 0);
      issue("rd_byte3",  0, 2'b10, 32'h403, 32'h0,        0, 32'h00000055, 2, 0);
      issue("rd_word7",  0, 2'b00, 32'h10, 32'h0,         0, 32'h1234BEEF, 2, 0);

      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
